// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned DefaultTimeout = 64;
   localparam int unsigned DefaultToWidth = 7;

   // Arbiter sequencing states.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StServeI = 2'd1,
      StServeD = 2'd2,
      StResp   = 2'd3
   } arb_state_e;

   // Requesting port identity, used for both the current owner and the last grant.
   typedef enum logic {
      PortI = 1'b0,
      PortD = 1'b1
   } port_e;

   // Latched copy of a granted request, driven onto the memory bus while serving.
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Choose which port to grant. On a tie the port that was not granted last wins,
   // so after reset (last grant = I) data wins the first tie and ties alternate after.
   function automatic port_e pick_port(input logic i_req, input logic d_req, input port_e last);
      port_e sel;
      if (i_req && d_req) begin
         sel = (last == PortI) ? PortD : PortI;
      end else if (d_req) begin
         sel = PortD;
      end else begin
         sel = PortI;
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog: counts serving cycles and pulses expire on the last allowed cycle.
module mem_arb_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT  = DefaultTimeout,
   parameter int unsigned TO_WIDTH = DefaultToWidth
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [TO_WIDTH-1:0] LastCount = TO_WIDTH'(TIMEOUT - 1);

   logic [TO_WIDTH-1:0] cnt_q;

   // Cycle counter: cleared on each grant, advances only while a transaction is served.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + TO_WIDTH'(1);
      end
   end

   // Expiry fires on the TIMEOUT-th serving cycle (count 0 is the first).
   always_comb begin
      expire = enable && (cnt_q == LastCount);
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one handshaked memory between instruction fetch and data access.
// A granted request is latched, presented to memory until ack or timeout, and completed with
// a single response cycle in which the owning port's stall drops.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT  = DefaultTimeout,
   parameter int unsigned TO_WIDTH = DefaultToWidth
) (
   input  logic        clk,
   input  logic        rst,
   // Instruction fetch port
   input  logic        i_cs,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_stall,
   // Data access port
   input  logic        d_cs,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_stall,
   // Shared memory
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack,
   // Status
   output logic        err_timeout
);

   arb_state_e  state_q, state_d;
   port_e       owner_q, owner_d;
   port_e       last_grant_q, last_grant_d;
   port_e       grant_port;
   mem_req_t    req_q, req_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        err_q, err_d;
   logic        serving;
   logic        grant;
   logic        wd_expire;

   assign serving = (state_q == StServeI) || (state_q == StServeD);

   mem_arb_watchdog #(
      .TIMEOUT  (TIMEOUT),
      .TO_WIDTH (TO_WIDTH)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (grant),
      .enable (serving),
      .expire (wd_expire)
   );

   // Next-state: grant from idle, finish on ack or watchdog expiry, single response cycle.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      req_d        = req_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      err_d        = err_q;
      grant        = 1'b0;
      grant_port   = pick_port(i_cs, d_cs, last_grant_q);

      unique case (state_q)
         StIdle: begin
            if (i_cs || d_cs) begin
               grant        = 1'b1;
               owner_d      = grant_port;
               last_grant_d = grant_port;
               if (grant_port == PortD) begin
                  req_d   = '{we: d_we, addr: d_addr, wdata: d_wdata};
                  state_d = StServeD;
               end else begin
                  req_d   = '{we: 1'b0, addr: i_addr, wdata: 32'h0};
                  state_d = StServeI;
               end
            end
         end

         StServeI, StServeD: begin
            if (m_ack) begin
               // Writes complete without touching the read-data register.
               if (!req_q.we) begin
                  if (owner_q == PortD) begin
                     d_rdata_d = m_rdata;
                  end else begin
                     i_rdata_d = m_rdata;
                  end
               end
               state_d = StResp;
            end else if (wd_expire) begin
               if (owner_q == PortD) begin
                  d_rdata_d = 32'h0;
               end else begin
                  i_rdata_d = 32'h0;
               end
               err_d   = 1'b1;
               state_d = StResp;
            end
         end

         StResp: begin
            // No grant here: a still-held request from the finished port must not re-issue.
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset also abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= PortI;
         last_grant_q <= PortI;
         req_q        <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         req_q        <= req_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         err_q        <= err_d;
      end
   end

   // Memory bus and requester outputs; a port is released only in its own response cycle.
   always_comb begin
      m_req       = serving;
      m_we        = serving && req_q.we;
      m_addr      = req_q.addr;
      m_wdata     = req_q.wdata;
      i_rdata     = i_rdata_q;
      d_rdata     = d_rdata_q;
      err_timeout = err_q;
      i_stall     = i_cs && !((state_q == StResp) && (owner_q == PortI));
      d_stall     = d_cs && !((state_q == StResp) && (owner_q == PortD));
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of grants, latency and read data.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_cs;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_stall;
   logic        d_cs;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack;
   logic        err_timeout;

   int checks;
   int failures;

   // Reference model state
   bit          last_d;
   logic [31:0] i_rd_m;
   logic [31:0] d_rd_m;
   bit          err_m;

   // Memory responder controls
   int          mem_lat;
   logic [31:0] mem_data;
   bit          force_ack;
   int          req_cnt;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .TIMEOUT  (TIMEOUT),
      .TO_WIDTH (7)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_cs        (i_cs),
      .i_addr      (i_addr),
      .i_rdata     (i_rdata),
      .i_stall     (i_stall),
      .d_cs        (d_cs),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_stall     (d_stall),
      .m_req       (m_req),
      .m_we        (m_we),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_rdata     (m_rdata),
      .m_ack       (m_ack),
      .err_timeout (err_timeout)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Arbitration rule: a lone requester wins; on a tie the port not granted last wins.
   function automatic bit winner(input bit ic, input bit dc);
      return (ic && dc) ? !last_d : dc;
   endfunction

   // Memory model: acks on the mem_lat-th cycle of m_req (0 = never), plus a forced ack.
   initial begin
      m_ack   = 1'b0;
      m_rdata = 32'h0;
      req_cnt = 0;
      forever begin
         @(negedge clk);
         if (m_req) req_cnt++;
         else req_cnt = 0;
         m_ack   = force_ack || (m_req && mem_lat > 0 && req_cnt == mem_lat);
         m_rdata = m_ack ? mem_data : $urandom;
      end
   end

   // One complete transaction starting in the cycle the request is visible in idle.
   // Expect 1 grant cycle, lat (or TIMEOUT) serving cycles, then exactly one response cycle.
   task automatic serve_one(input bit pd, input int lat, input logic [31:0] rd, input int drop_at);
      int          n;
      bit          timed_out;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      we        = pd ? d_we : 1'b0;
      addr      = pd ? d_addr : i_addr;
      wd        = d_wdata;
      timed_out = (lat == 0 || lat > TIMEOUT);
      n         = timed_out ? TIMEOUT : lat;
      mem_lat   = lat;
      mem_data  = rd;

      @(negedge clk);
      chk1("grant_mreq", m_req, 1'b0);
      chk1("grant_stall", pd ? d_stall : i_stall, 1'b1);

      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk1("serve_mreq", m_req, 1'b1);
         chk32("serve_maddr", m_addr, addr);
         chk1("serve_mwe", m_we, we);
         if (we) chk32("serve_mwdata", m_wdata, wd);
         chk1("serve_own_stall", pd ? d_stall : i_stall, pd ? d_cs : i_cs);
         chk1("serve_other_stall", pd ? i_stall : d_stall, pd ? i_cs : d_cs);
         chk1("serve_err", err_timeout, err_m);
         // Owner's inputs wander during service; the latched request must not follow.
         if (pd) begin
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_we    = ($urandom_range(0, 1) == 1);
            if (k == drop_at) d_cs = 1'b0;
         end else begin
            i_addr = $urandom;
            if (k == drop_at) i_cs = 1'b0;
         end
      end

      @(negedge clk);
      chk1("resp_mreq", m_req, 1'b0);
      chk1("resp_own_stall", pd ? d_stall : i_stall, 1'b0);
      chk1("resp_other_stall", pd ? i_stall : d_stall, pd ? i_cs : d_cs);
      if (timed_out) begin
         exp_rd = 32'h0;
         err_m  = 1'b1;
      end else if (we) begin
         exp_rd = d_rd_m;
      end else begin
         exp_rd = rd;
      end
      if (pd) d_rd_m = exp_rd;
      else i_rd_m = exp_rd;
      chk32("resp_i_rdata", i_rdata, i_rd_m);
      chk32("resp_d_rdata", d_rdata, d_rd_m);
      chk1("resp_err", err_timeout, err_m);
      last_d = pd;
   endtask

   initial begin
      bit wi;
      bit wdq;
      bit first;
      int lat1;
      int lat2;
      int drop;

      checks    = 0;
      failures  = 0;
      last_d    = 1'b0;
      i_rd_m    = 32'h0;
      d_rd_m    = 32'h0;
      err_m     = 1'b0;
      mem_lat   = 0;
      mem_data  = 32'h0;
      force_ack = 1'b0;
      rst       = 1'b1;
      i_cs      = 1'b0;
      i_addr    = 32'h0;
      d_cs      = 1'b0;
      d_we      = 1'b0;
      d_addr    = 32'h0;
      d_wdata   = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("rst_mreq", m_req, 1'b0);
      chk1("rst_mwe", m_we, 1'b0);
      chk32("rst_maddr", m_addr, 32'h0);
      chk32("rst_mwdata", m_wdata, 32'h0);
      chk32("rst_irdata", i_rdata, 32'h0);
      chk32("rst_drdata", d_rdata, 32'h0);
      chk1("rst_err", err_timeout, 1'b0);
      chk1("rst_istall", i_stall, 1'b0);
      chk1("rst_dstall", d_stall, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;

      // First tie after reset: data first, fetch stalled throughout, then fetch
      @(posedge clk); #1;
      i_cs = 1'b1; i_addr = 32'h20;
      d_cs = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      serve_one(1'b1, 4, 32'hCAFEF00D, -1);
      @(posedge clk); #1;
      d_cs = 1'b0;
      serve_one(1'b0, 2, 32'h0BADF00D, -1);
      @(posedge clk); #1;
      i_cs = 1'b0;

      // Fetch only, 8-cycle memory latency
      @(posedge clk); #1;
      i_cs = 1'b1; i_addr = 32'h10;
      serve_one(1'b0, 8, 32'hDEADBEEF, -1);
      @(posedge clk); #1;
      i_cs = 1'b0;

      // Both held continuously: D, I, D, I with single-cycle responses
      @(posedge clk); #1;
      i_cs = 1'b1; d_cs = 1'b1; i_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0;
      for (int t = 0; t < 4; t++) begin
         serve_one((t % 2) == 0, 1 + t, $urandom, -1);
         @(posedge clk); #1;
         if (t == 3) begin
            i_cs = 1'b0;
            d_cs = 1'b0;
         end else begin
            i_addr = 32'h100 + 32'(t);
            d_addr = 32'h200 + 32'(t);
            d_we   = 1'b0;
         end
      end

      // Write: strobe and data presented, read data untouched
      @(posedge clk); #1;
      d_cs = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
      serve_one(1'b1, 3, 32'h55AA55AA, -1);
      @(posedge clk); #1;
      d_cs = 1'b0;

      // Ack on the final allowed cycle still succeeds
      @(posedge clk); #1;
      i_cs = 1'b1; i_addr = 32'h44;
      serve_one(1'b0, TIMEOUT, 32'h600DCAFE, -1);
      @(posedge clk); #1;
      i_cs = 1'b0;

      // Timeout on a data read, then a good access keeps the sticky flag
      @(posedge clk); #1;
      d_cs = 1'b1; d_we = 1'b0; d_addr = 32'h300;
      serve_one(1'b1, 0, 32'h11111111, -1);
      @(posedge clk); #1;
      d_cs = 1'b0;
      @(posedge clk); #1;
      i_cs = 1'b1; i_addr = 32'h48;
      serve_one(1'b0, 2, 32'h22222222, -1);
      @(posedge clk); #1;
      i_cs = 1'b0;

      // Request withdrawn mid-service still completes
      @(posedge clk); #1;
      d_cs = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      serve_one(1'b1, 5, 32'h33333333, 1);
      @(posedge clk); #1;
      d_cs = 1'b0;

      // Reset mid-transaction, late ack ignored, fresh fetch afterwards
      @(posedge clk); #1;
      i_cs = 1'b1; i_addr = 32'h600; mem_lat = 0; mem_data = 32'hA5A5A5A5;
      @(negedge clk);
      repeat (3) @(negedge clk);
      chk1("midrst_pre_mreq", m_req, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1; i_cs = 1'b0;
      @(posedge clk); #1;
      rst    = 1'b0;
      last_d = 1'b0;
      i_rd_m = 32'h0;
      d_rd_m = 32'h0;
      err_m  = 1'b0;
      @(negedge clk);
      chk1("midrst_mreq", m_req, 1'b0);
      chk1("midrst_err", err_timeout, 1'b0);
      chk32("midrst_maddr", m_addr, 32'h0);
      chk1("midrst_istall", i_stall, 1'b0);
      @(posedge clk); #1;
      force_ack = 1'b1;
      @(posedge clk); #1;
      force_ack = 1'b0;
      @(negedge clk);
      chk1("late_ack_mreq", m_req, 1'b0);
      chk32("late_ack_irdata", i_rdata, 32'h0);
      chk32("late_ack_drdata", d_rdata, 32'h0);
      @(posedge clk); #1;
      i_cs = 1'b1; i_addr = 32'h700;
      serve_one(1'b0, 3, 32'h76543210, -1);
      @(posedge clk); #1;
      i_cs = 1'b0;

      // Randomized traffic
      for (int t = 0; t < 30; t++) begin
         wi  = ($urandom_range(0, 1) == 1);
         wdq = ($urandom_range(0, 1) == 1);
         if (!wi && !wdq) wi = 1'b1;
         lat1 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
         lat2 = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
         drop = ($urandom_range(0, 3) == 0) ? 0 : -1;
         @(posedge clk); #1;
         i_cs    = wi;
         i_addr  = $urandom;
         d_cs    = wdq;
         d_we    = ($urandom_range(0, 1) == 1);
         d_addr  = $urandom;
         d_wdata = $urandom;
         first   = winner(wi, wdq);
         serve_one(first, lat1, $urandom, drop);
         @(posedge clk); #1;
         if (first) d_cs = 1'b0;
         else i_cs = 1'b0;
         if (wi && wdq) begin
            serve_one(!first, lat2, $urandom, -1);
            @(posedge clk); #1;
            i_cs = 1'b0;
            d_cs = 1'b0;
         end
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
